// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag indices and result-queue entry type
package alu_pkg;
  localparam int RES_W = 16;
  localparam int OP_W = 4;
  localparam int FLAG_W = 3;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
  localparam logic [OP_W-1:0] OP_SAR = 4'b1000;
  localparam logic [OP_W-1:0] OP_PASSA = 4'b1001;
  localparam logic [OP_W-1:0] OP_PASSB = 4'b1010;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
  localparam logic [OP_W-1:0] OP_ROTL = 4'b1100;
  localparam logic [OP_W-1:0] OP_ROTR = 4'b1101;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  typedef struct packed {
    logic [RES_W-1:0] y;
    logic [OP_W-1:0] op;
    logic [FLAG_W-1:0] flags;
  } result_t;
  // carry is only meaningful for the arithmetic opcodes
  function automatic logic [FLAG_W-1:0] calc_flags(input logic [OP_W-1:0] op, input logic [RES_W-1:0] y, input logic cout);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_Z] = (y == '0);
    f[FLAG_N] = y[RES_W-1];
    f[FLAG_C] = (op == OP_ADD || op == OP_SUB) ? cout : 1'b0;
    return f;
  endfunction
endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: parameterised FIFO storage with wrapping pointers and occupancy counter
module alu_sync_fifo #(
  parameter int W = 23,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [PTR_W:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  assign dout = mem[rp];
  // storage, pointers and occupancy; storage is cleared so the head reads zero after reset
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: captures 1-cycle-latency ALU results with flags into a credit-protected FIFO
module alu_result_queue import alu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_opcode,
  input  logic [RES_W-1:0]  alu_y,
  input  logic              alu_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [OP_W-1:0]   out_opcode,
  output logic [FLAG_W-1:0] out_flags,
  output logic [PTR_W:0]    occupancy
);
  logic inflight_q;
  logic [OP_W-1:0] tag_q;
  logic fire, pop;
  result_t din, dout;
  logic [PTR_W+1:0] credits_used;
  // an in-flight result already owns a slot; same-cycle pops are ignored to keep out_ready off this path
  always_comb begin
    credits_used = {1'b0, occupancy} + {{(PTR_W+1){1'b0}}, inflight_q};
    issue_ready = credits_used < (PTR_W+2)'(DEPTH);
    fire = issue_valid & issue_ready;
    out_valid = occupancy != '0;
    pop = out_valid & out_ready;
    din = '{y: alu_y, op: tag_q, flags: calc_flags(tag_q, alu_y, alu_cout)};
    out_data = dout.y;
    out_opcode = dout.op;
    out_flags = dout.flags;
  end
  // remembers that the ALU output next cycle belongs to an accepted issue, and its opcode
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      inflight_q <= 1'b0;
      tag_q <= '0;
    end else begin
      inflight_q <= fire;
      if (fire) tag_q <= issue_opcode;
    end
  alu_sync_fifo #(.W($bits(result_t)), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .push(inflight_q),
    .pop(pop),
    .din(din),
    .dout(dout),
    .count(occupancy)
  );
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: randomized and directed checks against a queue-based reference model
module tb_alu_result_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  typedef struct {
    logic [15:0] y;
    logic [3:0] op;
    logic [2:0] f;
  } entry_t;
  logic CLK = 0, RST = 1;
  logic issue_valid = 0, out_ready = 0, alu_cout = 0;
  logic [3:0] issue_opcode = 0;
  logic [15:0] alu_y = 0;
  logic issue_ready, out_valid;
  logic [15:0] out_data;
  logic [3:0] out_opcode;
  logic [2:0] out_flags;
  logic [PTR_W:0] occupancy;
  entry_t q[$];
  bit pend;
  logic [3:0] ptag;
  int n_checks = 0, n_fail = 0;
  alu_result_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_opcode(out_opcode), .out_flags(out_flags), .occupancy(occupancy)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] ref_flags(input logic [3:0] op, input logic [15:0] y, input logic c);
    logic carry, neg, zero;
    carry = (op <= 4'd1) && c;
    neg = y >= 16'h8000;
    zero = y == 16'd0;
    return {carry, neg, zero};
  endfunction
  task automatic compare_all();
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("issue_ready", 32'(issue_ready), 32'(q.size() + int'(pend) < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(q[0].y));
      check("out_opcode", 32'(out_opcode), 32'(q[0].op));
      check("out_flags", 32'(out_flags), 32'(q[0].f));
    end
  endtask
  // one clock cycle: drive at negedge, compare, then advance the model at the posedge
  task automatic step(input logic iv, input logic [3:0] op, input logic [15:0] y, input logic c, input logic ordy);
    bit fire;
    @(negedge CLK);
    issue_valid = iv; issue_opcode = op; alu_y = y; alu_cout = c; out_ready = ordy;
    #1 compare_all();
    @(posedge CLK);
    fire = iv && (q.size() + int'(pend) < DEPTH);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (pend) begin
      check("no_overflow", 32'(q.size() < DEPTH), 32'd1);
      q.push_back('{y: y, op: ptag, f: ref_flags(ptag, y, c)});
    end
    pend = fire;
    if (fire) ptag = op;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || pend); i++) step(0, 4'd0, 16'($urandom), 1'($urandom), 1);
  endtask
  initial begin
    pend = 0; ptag = 0;
    #12;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_opcode", 32'(out_opcode), 0);
    check("rst_flags", 32'(out_flags), 0);
    @(negedge CLK); RST = 0;
    #1 check("rst_ready", 32'(issue_ready), 1);
    step(1, 4'b0000, 16'h1234, 0, 0);
    step(0, 4'd0, 16'h0000, 1, 0);
    #1;
    check("add_valid", 32'(out_valid), 1);
    check("add_data", 32'(out_data), 0);
    check("add_flags", 32'(out_flags), 3'b101);
    check("add_occ", 32'(occupancy), 1);
    drain();
    for (int i = 0; i < 4; i++) step(1, 4'(i), 16'(i * 3 + 1), 1'(i), 0);
    #1 check("fill_ready_low", 32'(issue_ready), 0);
    step(1, 4'd5, 16'h0bad, 0, 0);
    #1 check("fill_occ", 32'(occupancy), 4);
    step(1, 4'd6, 16'h0bad, 0, 0);
    #1 check("fill_sat", 32'(occupancy), 4);
    check("fill_full_ready", 32'(issue_ready), 0);
    step(0, 4'd0, 16'h0, 0, 1);
    #1 check("pop_occ", 32'(occupancy), 3);
    check("pop_ready", 32'(issue_ready), 1);
    drain();
    for (int i = 0; i < 20; i++) begin
      step(1, 4'(i % 14), 16'h8000 + 16'(i - 1), 1'($urandom), 1);
      #1 check("stream_occ_le1", 32'(occupancy <= 1), 1);
      if (i > 1) check("stream_n", 32'(out_flags[1]), 1);
    end
    drain();
    step(1, 4'b0110, 16'h0, 0, 0);
    step(0, 4'd0, 16'h0005, 1, 0);
    #1 check("shl_no_carry", 32'(out_flags), 3'b000);
    drain();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 4'($urandom_range(0, 13)), 16'($urandom), 1'($urandom), 0);
      drain();
    end
    step(1, 4'd0, 16'h1111, 0, 0);
    step(1, 4'd1, 16'h2222, 1, 0);
    step(1, 4'd2, 16'h3333, 1, 0);
    #1 check("pre_rst_occ", 32'(occupancy), 2);
    #1 RST = 1; issue_valid = 0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_occ", 32'(occupancy), 0);
    q.delete(); pend = 0;
    #1 RST = 0;
    step(0, 4'd0, 16'h7777, 1, 0);
    step(0, 4'd0, 16'h7777, 1, 0);
    #1 check("post_rst_empty", 32'(out_valid), 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
